pipelined_cla_addsub: RTL

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

---
 rtl/pipelined_cla_addsub_if.sv | 34 +++
 rtl/pipelined_cla_addsub.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Operand and result handshake bundle for pipelined_cla_addsub.
// Latency: none. This is wiring only.
// Backpressure: the slave drives in_ready; the master drives out_ready.
//
// Ports: in_valid/in_ready/a/b/sub/sat form the operand beat.
//        out_valid/out_ready/s/c_out/ovf/zero/neg form the result beat.
// master = producer of operands and consumer of results; slave = the adder.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero, neg
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: each stage handles one 16-bit slice with a carry-lookahead adder.
// Latency: NSTG = WIDTH/16 cycles. Throughput is one beat per cycle.
// Backpressure: a single global advance (!out_valid || out_ready) freezes every stage. in_ready equals that advance.
//
// Ports: clk, rst_n (async, active low); bus = pipelined_cla_addsub_if.slave
//        (operands a, b, sub, sat in; s, c_out, ovf, zero, neg out, valid/ready on both sides).
// Optional feature: define CLA_PIPE_SATURATE_EN to saturate s on signed overflow when sat=1.
//        Without it, sat is ignored and s is always the modular result.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int NSTG = WIDTH / 16;

    // 4-bit lookahead carries c[1..4] from generate/propagate and c0.
    // The same equations serve the bit groups and the group-level unit.
    function automatic logic [4:1] lac4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:1] c;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // 16-bit CLA. The result is {carry into bit 15, carry out, sum[15:0]}.
    function automatic logic [17:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        logic [16:0] c;
        logic [4:1]  t;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < 4; j++) begin
            t     = lac4(g[4*j +: 4], p[4*j +: 4], 1'b0);
            gg[j] = t[4];
            gp[j] = &p[4*j +: 4];
        end
        gc[0]   = cin;
        gc[4:1] = lac4(gg, gp, cin);
        for (int j = 0; j < 4; j++) begin
            t              = lac4(g[4*j +: 4], p[4*j +: 4], gc[j]);
            c[4*j]         = gc[j];
            c[4*j+1 +: 3]  = t[3:1];
        end
        c[16] = gc[4];
        return {c[15], c[16], p ^ c[15:0]};
    endfunction

    logic adv;

    assign adv          = !stg[NSTG-1].vld_q || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int LO = 16 * k;
        localparam int HI = LO + 16;

        // Operand bits still to be added, with this stage's slice at the bottom.
        logic [WIDTH-LO-1:0] a_rem;
        logic [WIDTH-LO-1:0] b_rem;
        logic                vld_in;
        logic                c_in;
        logic                z_in;
        logic [HI-1:0]       sum_nxt;
        logic [17:0]         res;
        logic                vld_q;
        logic                c_q;
        logic                z_q;
        logic [HI-1:0]       sum_q;

        assign res = cla16(a_rem[15:0], b_rem[15:0], c_in);

        if (k == 0) begin : src
            // For subtraction, B is inverted here and sub enters as the +1 carry.
            assign a_rem   = bus.a;
            assign b_rem   = bus.b ^ {WIDTH{bus.sub}};
            assign vld_in  = bus.in_valid;
            assign c_in    = bus.sub;
            assign z_in    = 1'b1;
            assign sum_nxt = res[15:0];
        end else begin : src
            assign a_rem   = stg[k-1].skw.a_q;
            assign b_rem   = stg[k-1].skw.b_q;
            assign vld_in  = stg[k-1].vld_q;
            assign c_in    = stg[k-1].c_q;
            assign z_in    = stg[k-1].z_q;
            assign sum_nxt = {res[15:0], stg[k-1].sum_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                z_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                c_q   <= res[16];
                z_q   <= z_in & (res[15:0] == 16'h0);
                sum_q <= sum_nxt;
            end
        end

        // Skew registers: upper slices wait here until their stage comes up.
        if (HI < WIDTH) begin : skw
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_rem[WIDTH-LO-1:16];
                    b_q <= b_rem[WIDTH-LO-1:16];
                end
            end
        end

        // Only the top slice needs the carry into the MSB, to derive overflow.
        if (k == NSTG - 1) begin : lst
            logic cm_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cm_q <= 1'b0;
                end else if (adv) begin
                    cm_q <= res[17];
                end
            end
        end else begin : mid
            logic unused_cm;
            assign unused_cm = res[17];
        end

`ifdef CLA_PIPE_SATURATE_EN
        // The sat request travels with its beat.
        logic sat_in;
        logic sat_q;
        if (k == 0) begin : sat_src
            assign sat_in = bus.sat;
        end else begin : sat_src
            assign sat_in = stg[k-1].sat_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sat_q <= 1'b0;
            end else if (adv) begin
                sat_q <= sat_in;
            end
        end
`endif
    end

    logic [WIDTH-1:0] s_mod;
    logic [WIDTH-1:0] s_fin;
    logic             c_last;
    logic             ovf_w;
    logic             z_mod;

    assign s_mod  = stg[NSTG-1].sum_q;
    assign c_last = stg[NSTG-1].c_q;
    assign z_mod  = stg[NSTG-1].z_q;
    assign ovf_w  = stg[NSTG-1].lst.cm_q ^ c_last;

`ifdef CLA_PIPE_SATURATE_EN
    logic sat_hit;
    assign sat_hit = stg[NSTG-1].sat_q & ovf_w;
    // On overflow the modular sign is the opposite of the true sign.
    // So an MSB of 1 means the true result was positive.
    assign s_fin   = !sat_hit   ? s_mod :
                     s_mod[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign bus.zero = z_mod & !sat_hit;
`else
    logic unused_sat;
    assign unused_sat = bus.sat;
    assign s_fin      = s_mod;
    assign bus.zero   = z_mod;
`endif

    assign bus.out_valid = stg[NSTG-1].vld_q;
    assign bus.s         = s_fin;
    assign bus.c_out     = c_last;
    assign bus.ovf       = ovf_w;
    assign bus.neg       = s_fin[WIDTH-1];
endmodule
